ex_mem_register: RTL
====================

# ex_mem_register

Pipeline register between the execute stage and the memory stage. Captures the execute-stage result, its four ALU status flags, store data, destination register and memory/write-back controls on each clock. It also holds the architectural condition-flag register (NZVC) that later conditional instructions read. Supports stall and flush from the hazard unit, drives a forwarding port back to execute, and counts inserted bubbles for performance debug.

## Interface
Parameters:
- N, 8, datapath width (matches ALU width)
- REG_ADDR_W, 4, register-file address width
- CNT_W, 16, bubble counter width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold all state this cycle
- flush  input  1  squash the instruction entering from EX
- ex_valid  input  1  EX holds a real instruction
- ex_result  input  N  ALU result
- ex_flags  input  4  ALU flags: [3]=N, [2]=Z, [1]=V, [0]=C
- ex_store_data  input  N  register value for stores
- ex_rd  input  REG_ADDR_W  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_set_flags  input  1 each  controls
- mem_valid  output  1  registered valid
- mem_result, mem_store_data  output  N  registered data
- mem_rd  output  REG_ADDR_W  registered destination
- mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg  output  1 each  registered controls
- cond_flags  output  4  architectural NZVC register
- fwd_en  output  1  forwarding data valid
- fwd_rd  output  REG_ADDR_W  forwarded register index
- fwd_data  output  N  forwarded value
- bubble_count  output  CNT_W  saturating bubble counter

## Operation
- One clock. Reset is asynchronous and active-high. Update priority per edge is rst > flush > stall > load.
- rst: every registered output goes to 0, including mem_valid, all data and controls, cond_flags = 4'b0000 and bubble_count = 0.
- flush = 1, regardless of stall:
  - mem_valid, all mem_* controls, mem_result, mem_store_data and mem_rd load 0.
  - cond_flags holds.
  - bubble_count increments.
- stall = 1 with flush = 0: every register holds, including cond_flags and bubble_count.
- Load, with stall = 0 and flush = 0:
  - ex_valid = 1: all mem_* fields capture their ex_* inputs and mem_valid = 1.
  - ex_valid = 0: the stage behaves exactly like a flush (all fields 0, bubble_count increments).
- cond_flags loads ex_flags only on a load edge with ex_valid = 1 and ex_set_flags = 1. Otherwise it holds.
- A squashed, stalled or invalid instruction never changes cond_flags.
- bubble_count saturates at 2^CNT_W−1 and does not wrap.
- Forwarding is combinational from the registers only, with no path from ex_* inputs:
  - fwd_en = mem_valid & mem_reg_write & ~mem_mem_to_reg.
  - fwd_rd = mem_rd.
  - fwd_data = mem_result.
- Loads (mem_mem_to_reg = 1) never forward. The hazard unit stalls for them.
- Flags pass through as 4-bit values and are never recomputed. Data fields are unsigned bit copies with no width conversion.

## Timing
- Latency is 1 cycle: ex_* sampled at edge k appears on mem_* and cond_flags after edge k.
- All outputs are registered except the fwd_* outputs, which are registered values through AND logic only.
- Stall held for M cycles means outputs are frozen for M cycles. On the first non-stall edge the current ex_* inputs are captured.
- flush and stall asserted together: flush wins and a bubble is inserted.
- rst asserted mid-operation clears outputs immediately, without waiting for clk. After deassertion, the first edge performs a normal load.
- Counter increment and saturation resolve on the same edge.

## Test plan
- Reset mid-stream: drive ex_result = 8'h5A with ex_valid = 1, load, then pulse rst between edges -> all outputs 0 immediately, cond_flags = 0, bubble_count = 0.
- Normal load and flags: ex_result = 8'h80, ex_flags = 4'b1000, ex_set_flags = 1, ex_rd = 3, ex_reg_write = 1 -> after one edge mem_result = 8'h80, cond_flags = 4'b1000, fwd_en = 1, fwd_rd = 3, fwd_data = 8'h80.
- Stall hold: load 8'h11, then stall for 3 cycles while ex_result = 8'h22 and ex_set_flags = 1 with ex_flags = 4'b0100 -> mem_result stays 8'h11, cond_flags unchanged. 8'h22 is captured on the first unstalled edge.
- Flush priority: flush = 1 and stall = 1 with ex_valid = 1, ex_flags = 4'b0011, ex_set_flags = 1 -> mem_valid = 0, all controls 0, cond_flags unchanged, bubble_count +1.
- Load no-forward: ex_mem_read = 1, ex_mem_to_reg = 1, ex_reg_write = 1, ex_rd = 5 -> mem_valid = 1, fwd_en = 0.
- Counter saturation with CNT_W = 4: drive ex_valid = 0 for 20 cycles -> bubble_count reaches 4'hF and holds at 4'hF.

Source files
------------

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register with the architectural NZVC flag register,
// a combinational forwarding port and a saturating bubble counter.
module ex_mem_register #(
    parameter int unsigned N          = 8,
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [N-1:0]          ex_result,
    input  logic [3:0]            ex_flags,
    input  logic [N-1:0]          ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_set_flags,
    output logic                  mem_valid,
    output logic [N-1:0]          mem_result,
    output logic [N-1:0]          mem_store_data,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_mem_to_reg,
    output logic [3:0]            cond_flags,
    output logic                  fwd_en,
    output logic [REG_ADDR_W-1:0] fwd_rd,
    output logic [N-1:0]          fwd_data,
    output logic [CNT_W-1:0]      bubble_count
);

    logic bubble;
    logic load;

    // A stall only outranks the invalid-instruction bubble, never a flush.
    assign bubble = flush | (~stall & ~ex_valid);
    assign load   = ~flush & ~stall & ex_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
        end else if (bubble) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_mem_to_reg <= 1'b0;
        end else if (load) begin
            mem_valid      <= 1'b1;
            mem_result     <= ex_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            mem_reg_write  <= ex_reg_write;
            mem_mem_read   <= ex_mem_read;
            mem_mem_write  <= ex_mem_write;
            mem_mem_to_reg <= ex_mem_to_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_flags <= '0;
        end else if (load && ex_set_flags) begin
            cond_flags <= ex_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count <= '0;
        end else if (bubble && (bubble_count != '1)) begin
            bubble_count <= bubble_count + CNT_W'(1);
        end
    end

    // Loads never forward; the hazard unit stalls for them instead.
    assign fwd_en   = mem_valid & mem_reg_write & ~mem_mem_to_reg;
    assign fwd_rd   = mem_rd;
    assign fwd_data = mem_result;

endmodule
